// File: rtl/elm_pkg.sv
// elm_pkg: shared widths and constants for the ELM approximate log-domain divider.
//   FRAC_W  mantissa fraction width (bits below the leading one)
//   OP_W    operand width
//   Q_W     quotient width (unsigned Q16.16)
//   COMP_C  mantissa correction subtracted when ELM_DIV_ERRCOMP_EN is defined
//   DZ_Q    quotient reported on divide-by-zero
package elm_pkg;

  localparam int unsigned FRAC_W = 15;
  localparam int unsigned OP_W   = 16;
  localparam int unsigned Q_W    = 32;
  localparam int unsigned K_W    = 4;
  localparam int unsigned E_W    = 6;

  localparam logic [FRAC_W-1:0] COMP_C = 15'h0200;
  localparam logic [Q_W-1:0]    DZ_Q   = 32'hFFFF_FFFF;

  // Leading-one decomposition of one operand.
  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [FRAC_W-1:0] f;
    logic              zero;
  } lod_t;

  // Log-difference result handed to the shifter stage; e is two's complement.
  typedef struct packed {
    logic [E_W-1:0]    e;
    logic [FRAC_W-1:0] m;
    logic              xz;
    logic              yz;
  } diff_t;

endpackage

// File: rtl/elm_div_lod.sv
// elm_div_lod: combinational 16-bit leading-one detector.
//   v     in  16  operand
//   k     out 4   index of the leading one (0 when v == 0)
//   f     out 15  bits below the leading one, left-aligned
//   zero  out 1   v == 0
module elm_div_lod
  import elm_pkg::*;
(
  input  logic [15:0] v,
  output logic [3:0]  k,
  output logic [14:0] f,
  output logic        zero
);

  always_comb begin
    k    = '0;
    zero = 1'b1;
    // Ascending scan: the last set bit seen is the leading one.
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        k    = i[3:0];
        zero = 1'b0;
      end
    end
    // Shifting the leading one up to bit 15 leaves the fraction in bits 14:0.
    f = FRAC_W'(v << (4'd15 - k));
  end

endmodule

// File: rtl/elm_div_top.sv
// elm_div_top: Mitchell-style approximate divider, q ~= x / y as unsigned Q16.16.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (x dividend, y divisor)
//   out_valid / out_ready result handshake (q quotient, dz divide-by-zero flag)
// Pipeline: S1 operand regs + LOD, S2 log subtract, S3 antilog shift into the output regs.
// Latency 3 edges from acceptance to out_valid; one global advance enable for all stages.
// Optional: define ELM_DIV_ERRCOMP_EN to subtract COMP_C from the mantissa when fx != fy.
module elm_div_top
  import elm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic        dz
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: operand registers and leading-one detection.
  logic              v1_q;
  logic [OP_W-1:0]   x1_q, y1_q;
  lod_t              lx_d, ly_d;

  elm_div_lod u_lod_x (
    .v    (x1_q),
    .k    (lx_d.k),
    .f    (lx_d.f),
    .zero (lx_d.zero)
  );

  elm_div_lod u_lod_y (
    .v    (y1_q),
    .k    (ly_d.k),
    .f    (ly_d.f),
    .zero (ly_d.zero)
  );

  // S2: log-domain subtract.
  logic              v2_q;
  lod_t              lx_q, ly_q;
  logic [OP_W-1:0]   d;
  diff_t             diff_d;

  always_comb begin
    d         = {1'b0, lx_q.f} - {1'b0, ly_q.f};
    // A negative fraction difference borrows one from the exponent.
    diff_d.e  = {2'b00, lx_q.k} - {2'b00, ly_q.k} - {{(E_W-1){1'b0}}, d[15]};
    // (2^15 + d) and d share their low 15 bits, so both branches reduce to d[14:0].
    diff_d.m  = d[FRAC_W-1:0];
`ifdef ELM_DIV_ERRCOMP_EN
    if (lx_q.f != ly_q.f) begin
      diff_d.m = (diff_d.m > COMP_C) ? diff_d.m - COMP_C : '0;
    end
`endif
    diff_d.xz = lx_q.zero;
    diff_d.yz = ly_q.zero;
  end

  // S3: antilog by barrel shift into the output register.
  logic              v3_q;
  diff_t             diff_q;
  logic [E_W-1:0]    s, s_neg;
  logic [Q_W-1:0]    mant;
  logic [Q_W-1:0]    q_d;
  logic              dz_d;

  always_comb begin
    s     = diff_q.e + 6'd1;
    s_neg = 6'd0 - s;
    mant  = {16'b0, 1'b1, diff_q.m};
    dz_d  = 1'b0;
    if (diff_q.yz) begin
      q_d  = DZ_Q;
      dz_d = 1'b1;
    end else if (diff_q.xz) begin
      q_d = '0;
    end else if (!s[E_W-1]) begin
      q_d = mant << s;      // s in 0..16, never overflows 32 bits
    end else begin
      q_d = mant >> s_neg;  // s in -15..-1, truncating
    end
  end

  logic           out_valid_q;
  logic [Q_W-1:0] q_q;
  logic           dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      v2_q        <= 1'b0;
      lx_q        <= '0;
      ly_q        <= '0;
      v3_q        <= 1'b0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dz_q        <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid;
      x1_q        <= x;
      y1_q        <= y;
      v2_q        <= v1_q;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      v3_q        <= v2_q;
      diff_q      <= diff_d;
      out_valid_q <= v3_q;
      if (v3_q) begin
        q_q  <= q_d;
        dz_q <= dz_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_elm_div_top.sv
// tb_elm_div_top: directed self-checking bench for elm_div_top.
module tb_elm_div_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic        dz;

  int checks = 0;
  int errors = 0;

  elm_div_top dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, leaving the bench at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one operand pair with out_ready held high and check latency and result.
  task automatic run_one(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [31:0] exp_q, input logic exp_dz);
    int lat;
    in_valid  = 1'b1;
    x         = xv;
    y         = yv;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_dz"}, 32'(dz), 32'(exp_dz));
    cycle();
    #1;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    @(negedge clk);
  endtask

  logic [15:0] sx [6] = '{16'd1, 16'd6, 16'd40, 16'h0100, 16'd3, 16'h8000};
  logic [15:0] sy [6] = '{16'd1, 16'd12, 16'd5, 16'h0010, 16'd96, 16'd1};
  logic [31:0] sq [6] = '{32'h0001_0000, 32'h0000_8000, 32'h0008_0000,
                          32'h0010_0000, 32'h0000_0800, 32'h8000_0000};

  initial begin
    int sent;
    int rcv;
    int extra;
    logic stall;
    logic [31:0] prev_q;

    // Reset state.
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_q", q, 32'd0);
    check("reset_dz", 32'(dz), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_one("div_8_2", 16'd8, 16'd2, 32'h0004_0000, 1'b0);
`ifdef ELM_DIV_ERRCOMP_EN
    run_one("div_100_7", 16'd100, 16'd7, 32'h000E_6000, 1'b0);
`else
    run_one("div_100_7", 16'd100, 16'd7, 32'h000E_8000, 1'b0);
`endif
    run_one("div_max_1", 16'hFFFF, 16'd1, 32'hFFFF_0000, 1'b0);
    run_one("div_1_max", 16'd1, 16'hFFFF, 32'h0000_0001, 1'b0);
    run_one("div_0_5", 16'd0, 16'd5, 32'h0000_0000, 1'b0);
    run_one("div_9_0", 16'd9, 16'd0, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back stream with a 4-cycle consumer stall.
    sent   = 0;
    rcv    = 0;
    prev_q = '0;
    for (int t = 0; t < 40 && rcv < 6; t++) begin
      stall     = (t >= 4 && t < 8);
      out_ready = !stall;
      in_valid  = (sent < 6);
      if (sent < 6) begin
        x = sx[sent];
        y = sy[sent];
      end
      #1;
      if (stall) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        if (t > 4) check("stall_q_hold", q, prev_q);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("stream_q%0d", rcv), q, sq[rcv]);
        rcv++;
      end
      prev_q = q;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(rcv), 32'd6);
    extra = 0;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (out_valid) extra++;
      cycle();
    end
    check("stream_no_dup", 32'(extra), 32'd0);

    // Reset with three operands in flight, one of them already at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x        = 16'(8 + i);
      y        = 16'd2;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_q", q, 32'd0);
    check("async_reset_dz", 32'(dz), 32'd0);
    cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    extra     = 0;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (out_valid) extra++;
      cycle();
    end
    check("post_reset_no_stale", 32'(extra), 32'd0);
    run_one("post_reset_40_5", 16'd40, 16'd5, 32'h0008_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
